// File: rtl/id_ex_pipe.sv
// id_ex_pipe
// ----------
// Front-end pipeline slice of the PPU datapath. Provides a combinational
// next-PC incrementer and the ID and EX pipeline registers that carry the
// 17-bit control word (and its PC) from the control-unit mux to the execute
// stage. The EX control word is broken out into named fields for the EX
// datapath and is also passed through whole to the MEM stage.
//
// Ports:
//   clk               in   1   system clock, rising-edge active
//   reset             in   1   asynchronous, active-low reset
//   npc_in            in  32   current nPC register value
//   npc_plus4         out 32   npc_in + 4 (combinational, wraps modulo 2^32)
//   ctrl_in           in  17   control word from control-unit mux
//   pc_in             in  32   PC of instruction entering ID
//   stall             in   1   hold ID, inject bubble into EX
//   flush             in   1   squash ID contents (wins over stall)
//   id_ctrl, id_pc    out      ID register contents
//   ex_ctrl, ex_pc    out      EX register contents
//   ex_alu_op .. ex_lo_enable  wiring slices of ex_ctrl
//
// Configuration:
//   ID_STALL_EN  defined   -> stall holds ID and bubbles EX.
//                undefined -> stall port is ignored; ID and EX always advance.

module id_ex_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    output logic [31:0] npc_plus4,
    input  logic [16:0] ctrl_in,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic [16:0] id_ctrl,
    output logic [31:0] id_pc,
    output logic [16:0] ex_ctrl,
    output logic [31:0] ex_pc,
    output logic [2:0]  ex_alu_op,
    output logic        ex_load_instr,
    output logic [2:0]  ex_source_operand,
    output logic        ex_rf_enable,
    output logic        ex_branch,
    output logic        ex_ta_instr,
    output logic        ex_mem_enable,
    output logic        ex_mem_se,
    output logic        ex_mem_rw,
    output logic [1:0]  ex_mem_size,
    output logic        ex_hi_enable,
    output logic        ex_lo_enable
);

    logic        stall_eff;
    logic [16:0] id_ctrl_q, id_ctrl_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [16:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0] ex_pc_q, ex_pc_d;

`ifdef ID_STALL_EN
    assign stall_eff = stall;
`else
    // Stall support compiled out: the port is kept for a stable interface.
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
`endif

    // Carry out of bit 31 is intentionally dropped.
    assign npc_plus4 = npc_in + 32'd4;

    always_comb begin
        id_ctrl_d = ctrl_in;
        id_pc_d   = pc_in;
        ex_ctrl_d = id_ctrl_q;
        ex_pc_d   = id_pc_q;

        if (flush) begin
            id_ctrl_d = 17'd0;
            id_pc_d   = 32'd0;
        end else if (stall_eff) begin
            id_ctrl_d = id_ctrl_q;
            id_pc_d   = id_pc_q;
        end

        // Bubble keeps the stalled instruction's PC but carries a NOP word.
        // With flush high, EX advances normally from the pre-edge ID contents.
        if (stall_eff && !flush) begin
            ex_ctrl_d = 17'd0;
            ex_pc_d   = id_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ctrl_q <= 17'd0;
            id_pc_q   <= 32'd0;
            ex_ctrl_q <= 17'd0;
            ex_pc_q   <= 32'd0;
        end else begin
            id_ctrl_q <= id_ctrl_d;
            id_pc_q   <= id_pc_d;
            ex_ctrl_q <= ex_ctrl_d;
            ex_pc_q   <= ex_pc_d;
        end
    end

    assign id_ctrl = id_ctrl_q;
    assign id_pc   = id_pc_q;
    assign ex_ctrl = ex_ctrl_q;
    assign ex_pc   = ex_pc_q;

    assign ex_alu_op         = ex_ctrl_q[2:0];
    assign ex_load_instr     = ex_ctrl_q[3];
    assign ex_source_operand = ex_ctrl_q[6:4];
    assign ex_rf_enable      = ex_ctrl_q[7];
    assign ex_branch         = ex_ctrl_q[8];
    assign ex_ta_instr       = ex_ctrl_q[9];
    assign ex_mem_enable     = ex_ctrl_q[10];
    assign ex_mem_se         = ex_ctrl_q[11];
    assign ex_mem_rw         = ex_ctrl_q[12];
    assign ex_mem_size       = ex_ctrl_q[14:13];
    assign ex_hi_enable      = ex_ctrl_q[15];
    assign ex_lo_enable      = ex_ctrl_q[16];

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: incrementer, reset, field split, stall,
// flush and flush+stall, reset mid-stall. Stall expectations follow whether
// ID_STALL_EN is defined for the build.

module tb_id_ex_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] npc_in;
    logic [31:0] npc_plus4;
    logic [16:0] ctrl_in;
    logic [31:0] pc_in;
    logic        stall;
    logic        flush;
    logic [16:0] id_ctrl;
    logic [31:0] id_pc;
    logic [16:0] ex_ctrl;
    logic [31:0] ex_pc;
    logic [2:0]  ex_alu_op;
    logic        ex_load_instr;
    logic [2:0]  ex_source_operand;
    logic        ex_rf_enable;
    logic        ex_branch;
    logic        ex_ta_instr;
    logic        ex_mem_enable;
    logic        ex_mem_se;
    logic        ex_mem_rw;
    logic [1:0]  ex_mem_size;
    logic        ex_hi_enable;
    logic        ex_lo_enable;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [16:0] CtrlA = 17'h00011;
    localparam logic [16:0] CtrlB = 17'h00022;
    localparam logic [16:0] CtrlC = 17'h00033;

    id_ex_pipe dut (
        .clk               (clk),
        .reset             (reset),
        .npc_in            (npc_in),
        .npc_plus4         (npc_plus4),
        .ctrl_in           (ctrl_in),
        .pc_in             (pc_in),
        .stall             (stall),
        .flush             (flush),
        .id_ctrl           (id_ctrl),
        .id_pc             (id_pc),
        .ex_ctrl           (ex_ctrl),
        .ex_pc             (ex_pc),
        .ex_alu_op         (ex_alu_op),
        .ex_load_instr     (ex_load_instr),
        .ex_source_operand (ex_source_operand),
        .ex_rf_enable      (ex_rf_enable),
        .ex_branch         (ex_branch),
        .ex_ta_instr       (ex_ta_instr),
        .ex_mem_enable     (ex_mem_enable),
        .ex_mem_se         (ex_mem_se),
        .ex_mem_rw         (ex_mem_rw),
        .ex_mem_size       (ex_mem_size),
        .ex_hi_enable      (ex_hi_enable),
        .ex_lo_enable      (ex_lo_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " id_ctrl"}, {15'd0, id_ctrl}, 32'd0);
        chk({tag, " id_pc"}, id_pc, 32'd0);
        chk({tag, " ex_ctrl"}, {15'd0, ex_ctrl}, 32'd0);
        chk({tag, " ex_pc"}, ex_pc, 32'd0);
        chk({tag, " ex_fields"},
            {15'd0, ex_lo_enable, ex_hi_enable, ex_mem_size, ex_mem_rw, ex_mem_se,
             ex_mem_enable, ex_ta_instr, ex_branch, ex_rf_enable, ex_source_operand,
             ex_load_instr, ex_alu_op}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        npc_in  = 32'd0;
        ctrl_in = 17'd0;
        pc_in   = 32'd0;
        stall   = 1'b0;
        flush   = 1'b0;

        // Incrementer, including wrap; also works while reset is low.
        #1;
        chk("inc 0", npc_plus4, 32'h0000_0004);
        npc_in = 32'h0000_01FC; #1;
        chk("inc 1FC", npc_plus4, 32'h0000_0200);
        npc_in = 32'hFFFF_FFFC; #1;
        chk("inc wrap", npc_plus4, 32'h0000_0000);

        chk_all_zero("reset initial");

        // Release reset and load the all-ones word.
        @(negedge clk);
        reset   = 1'b1;
        ctrl_in = 17'h1FFFF;
        pc_in   = 32'h40;
        step();
        chk("rst1 id_ctrl", {15'd0, id_ctrl}, 32'h1FFFF);
        chk("rst1 id_pc", id_pc, 32'h40);
        chk("rst1 ex_ctrl", {15'd0, ex_ctrl}, 32'd0);
        step();
        chk("rst2 ex_ctrl", {15'd0, ex_ctrl}, 32'h1FFFF);
        chk("rst2 ex_pc", ex_pc, 32'h40);
        chk("ones alu_op", {29'd0, ex_alu_op}, 32'd7);
        chk("ones src", {29'd0, ex_source_operand}, 32'd7);
        chk("ones size", {30'd0, ex_mem_size}, 32'd3);
        chk("ones bits",
            {22'd0, ex_lo_enable, ex_hi_enable, ex_mem_rw, ex_mem_se, ex_mem_enable,
             ex_ta_instr, ex_branch, ex_rf_enable, ex_load_instr, 1'b1}, 32'h3FF);

        // Asynchronous reset between edges clears everything at once.
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async reset");
        step();
        chk_all_zero("reset held over edge");
        reset = 1'b1;
        step();
        chk("after release id_ctrl", {15'd0, id_ctrl}, 32'h1FFFF);
        chk("after release ex_ctrl", {15'd0, ex_ctrl}, 32'd0);

        // Field split.
        ctrl_in = 17'b1_0_11_1_0_1_0_1_1_101_0_110;
        pc_in   = 32'h100;
        step();
        step();
        chk("fs alu_op", {29'd0, ex_alu_op}, 32'd6);
        chk("fs load", {31'd0, ex_load_instr}, 32'd0);
        chk("fs src", {29'd0, ex_source_operand}, 32'd5);
        chk("fs rf", {31'd0, ex_rf_enable}, 32'd1);
        chk("fs branch", {31'd0, ex_branch}, 32'd1);
        chk("fs ta", {31'd0, ex_ta_instr}, 32'd0);
        chk("fs mem_en", {31'd0, ex_mem_enable}, 32'd1);
        chk("fs se", {31'd0, ex_mem_se}, 32'd0);
        chk("fs rw", {31'd0, ex_mem_rw}, 32'd1);
        chk("fs size", {30'd0, ex_mem_size}, 32'd3);
        chk("fs hi", {31'd0, ex_hi_enable}, 32'd0);
        chk("fs lo", {31'd0, ex_lo_enable}, 32'd1);

        // Stall: A then B, stall high two cycles while B sits in ID.
        ctrl_in = CtrlA; pc_in = 32'd8;
        step();
        chk("st id A", {15'd0, id_ctrl}, {15'd0, CtrlA});
        ctrl_in = CtrlB; pc_in = 32'd12;
        step();
        chk("st ex A", {15'd0, ex_ctrl}, {15'd0, CtrlA});
        chk("st id B", {15'd0, id_ctrl}, {15'd0, CtrlB});
        ctrl_in = CtrlC; pc_in = 32'd16;
        stall   = 1'b1;
        step();
`ifdef ID_STALL_EN
        chk("st1 ex bubble", {15'd0, ex_ctrl}, 32'd0);
        chk("st1 ex_pc", ex_pc, 32'd12);
        chk("st1 id hold", {15'd0, id_ctrl}, {15'd0, CtrlB});
        chk("st1 id_pc hold", id_pc, 32'd12);
`else
        chk("nost1 ex B", {15'd0, ex_ctrl}, {15'd0, CtrlB});
        chk("nost1 id C", {15'd0, id_ctrl}, {15'd0, CtrlC});
`endif
        step();
`ifdef ID_STALL_EN
        chk("st2 ex bubble", {15'd0, ex_ctrl}, 32'd0);
        chk("st2 id hold", {15'd0, id_ctrl}, {15'd0, CtrlB});
`else
        chk("nost2 ex C", {15'd0, ex_ctrl}, {15'd0, CtrlC});
`endif
        stall = 1'b0;
        step();
`ifdef ID_STALL_EN
        chk("st3 ex B", {15'd0, ex_ctrl}, {15'd0, CtrlB});
        chk("st3 ex_pc", ex_pc, 32'd12);
`else
        chk("nost3 ex C", {15'd0, ex_ctrl}, {15'd0, CtrlC});
`endif
        chk("st3 id C", {15'd0, id_ctrl}, {15'd0, CtrlC});

        // Flush with B in ID.
        ctrl_in = CtrlB; pc_in = 32'd12;
        step();
        ctrl_in = CtrlC; pc_in = 32'd16;
        flush   = 1'b1;
        step();
        chk("fl id_ctrl", {15'd0, id_ctrl}, 32'd0);
        chk("fl id_pc", id_pc, 32'd0);
        chk("fl ex_ctrl", {15'd0, ex_ctrl}, {15'd0, CtrlB});
        chk("fl ex_pc", ex_pc, 32'd12);

        // Flush together with stall: stall ignored.
        flush   = 1'b0;
        ctrl_in = CtrlB; pc_in = 32'd12;
        step();
        ctrl_in = CtrlC; pc_in = 32'd16;
        flush   = 1'b1;
        stall   = 1'b1;
        step();
        chk("flst id_ctrl", {15'd0, id_ctrl}, 32'd0);
        chk("flst id_pc", id_pc, 32'd0);
        chk("flst ex_ctrl", {15'd0, ex_ctrl}, {15'd0, CtrlB});
        chk("flst ex_pc", ex_pc, 32'd12);

        // Reset in the middle of a stall leaves nothing behind.
        flush   = 1'b0;
        ctrl_in = CtrlA; pc_in = 32'd8;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("reset mid-stall");
        stall = 1'b0;
        ctrl_in = 17'd0; pc_in = 32'd0;
        step();
        reset = 1'b1;
        step();
        chk_all_zero("post reset nop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
